serial_addsub_unit: RTL and testbench

- Parametrised, digit-serial add/subtract unit; successor to the combinational ripple full-subtractor unit.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB first, with a registered carry/borrow between digits.
- Adds an ADD/SUB mode, a ready/valid handshake on both sides, and signed-overflow reporting.
- Sits in the arithmetic datapath where area matters more than latency.

---
 rtl/serial_addsub_unit_pkg.sv | 14 +
 rtl/serial_addsub_unit_if.sv | 44 ++++
 rtl/serial_addsub_unit_digit.sv | 34 +++
 rtl/serial_addsub_unit.sv | 134 +++++++++++++
 tb/tb_serial_addsub_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_unit_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
// FSM state encoding and op codes used by the top and the digit slice.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/serial_addsub_unit_if.sv
// Operand/result handshake bundle for serial_addsub_unit.
// master drives operands and result acceptance; slave is the unit.
interface serial_addsub_unit_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cb_out;
    logic             ovf;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  cb_out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output cb_out,
        output ovf
    );

endinterface

// File: rtl/serial_addsub_unit_digit.sv
// DIGIT-bit combinational ripple slice of full add/sub cells.
// cb_in/cb_next carry the carry (ADD) or the borrow (SUB).
module digit_addsub
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cb_in,
    input  logic             op,
    output logic [DIGIT-1:0] r_d,
    output logic             cb_next
);

    // Ripple the carry/borrow through the digit, LSB first
    always_comb begin
        logic c;
        r_d = '0;
        c   = cb_in;
        for (int i = 0; i < DIGIT; i++) begin
            r_d[i] = a_d[i] ^ b_d[i] ^ c;
            if (op == OP_ADD) begin
                c = (a_d[i] & b_d[i])
                  | ((a_d[i] ^ b_d[i]) & c);
            end else begin
                c = (~a_d[i] & b_d[i])
                  | (~(a_d[i] ^ b_d[i]) & c);
            end
        end
        cb_next = c;
    end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit: WIDTH bits, DIGIT bits per cycle.
// Optional macro SERIAL_ADDSUB_SAT_EN clamps the result on overflow.
module serial_addsub_unit
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                clk,
    input logic                rst_n,
    serial_addsub_unit_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_param_chk
        $error("serial_addsub_unit: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res_q;
    logic             op_q;
    logic             cb_q;
    logic             a_m;
    logic             b_m;
    logic             cb_out_q;
    logic             ovf_q;

    logic [DIGIT-1:0] r_d;
    logic             cb_next;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] res_fin;
    logic             r_m;
    logic             ovf_fin;

    digit_addsub #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a_d     (a_sr[DIGIT-1:0]),
        .b_d     (b_sr[DIGIT-1:0]),
        .cb_in   (cb_q),
        .op      (op_q),
        .r_d     (r_d),
        .cb_next (cb_next)
    );

    // Next result image and the overflow/saturation seen on the final digit
    always_comb begin
        acc_next = acc >> DIGIT;
        acc_next[WIDTH-1 -: DIGIT] = r_d;
        r_m = r_d[DIGIT-1];
        if (op_q == OP_SUB) begin
            ovf_fin = (a_m != b_m) && (r_m != a_m);
        end else begin
            ovf_fin = (a_m == b_m) && (r_m != a_m);
        end
        res_fin = acc_next;
`ifdef SERIAL_ADDSUB_SAT_EN
        // a_m = 0 means the true result overflowed upwards
        if (ovf_fin) begin
            res_fin = a_m ? {1'b1, {(WIDTH-1){1'b0}}}
                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Handshake FSM, operand shifting and result capture on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            acc      <= '0;
            res_q    <= '0;
            op_q     <= OP_SUB;
            cb_q     <= 1'b0;
            a_m      <= 1'b0;
            b_m      <= 1'b0;
            cb_out_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        op_q  <= bus.op;
                        a_m   <= bus.a[WIDTH-1];
                        b_m   <= bus.b[WIDTH-1];
                        cnt   <= '0;
                        cb_q  <= 1'b0;
                        state <= CALC;
                    end
                end
                (state == CALC): begin
                    a_sr <= a_sr >> DIGIT;
                    b_sr <= b_sr >> DIGIT;
                    acc  <= acc_next;
                    cb_q <= cb_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        res_q    <= res_fin;
                        cb_out_q <= cb_next;
                        ovf_q    <= ovf_fin;
                        state    <= DONE;
                    end
                end
                (state == DONE): begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res_q;
    assign bus.cb_out    = cb_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit (DIGIT=1 and DIGIT=4, WIDTH=8).
// Honours SERIAL_ADDSUB_SAT_EN when choosing expected results.
module tb_serial_addsub_unit;
    import serial_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_addsub_unit_if #(.WIDTH(8)) bus1 ();
    serial_addsub_unit_if #(.WIDTH(8)) bus4 ();

    serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    serial_addsub_unit #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res_wrap;
        logic [7:0] res_sat;
        logic       cb;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    int cyc = 0;
    int acc_t [16];
    int n_acc = 0;

    // Log the cycle index of every DIGIT=4 acceptance
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus4.in_valid && bus4.in_ready && n_acc < 16) begin
            acc_t[n_acc] <= cyc;
            n_acc <= n_acc + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic start1(input logic o, input logic [7:0] x,
                          input logic [7:0] y);
        bus1.op = o;
        bus1.a = x;
        bus1.b = y;
        bus1.in_valid = 1'b1;
        check("in_ready_idle", 32'(bus1.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus1.a = ~x;
        bus1.b = y ^ 8'h5A;
        bus1.op = ~o;
    endtask

    task automatic wait1(input int exp_lat);
        int k = 0;
        bit got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus1.out_valid) got = 1'b1;
            else check("in_ready_calc", 32'(bus1.in_ready), 32'd0);
        end
        check("latency1", 32'(k), 32'(exp_lat));
    endtask

    initial begin
        logic [7:0] exp_r;
        int k;
        int base;

        vecs[0] = '{OP_SUB, 8'h15, 8'h0A, 8'h0B, 8'h0B, 1'b0, 1'b0};
        vecs[1] = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{OP_SUB, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{OP_SUB, 8'h7F, 8'hFF, 8'h80, 8'h7F, 1'b1, 1'b1};
        vecs[8] = '{OP_ADD, 8'h12, 8'h34, 8'h46, 8'h46, 1'b0, 1'b0};

        bus1.in_valid = 1'b0;
        bus1.op = OP_SUB;
        bus1.a = '0;
        bus1.b = '0;
        bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.op = OP_SUB;
        bus4.a = '0;
        bus4.b = '0;
        bus4.out_ready = 1'b1;

        #12;
        check("rst_result", 32'(bus1.result), 32'd0);
        check("rst_cb", 32'(bus1.cb_out), 32'd0);
        check("rst_ovf", 32'(bus1.ovf), 32'd0);
        check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus1.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
`ifdef SERIAL_ADDSUB_SAT_EN
            exp_r = vecs[i].res_sat;
`else
            exp_r = vecs[i].res_wrap;
`endif
            start1(vecs[i].op, vecs[i].a, vecs[i].b);
            wait1(8);
            check("result", 32'(bus1.result), 32'(exp_r));
            check("cb_out", 32'(bus1.cb_out), 32'(vecs[i].cb));
            check("ovf", 32'(bus1.ovf), 32'(vecs[i].ovf));
            @(posedge clk);
            #1;
            check("back_to_idle", 32'(bus1.in_ready), 32'd1);
            check("held_in_idle", 32'(bus1.result), 32'(exp_r));
        end

        bus1.out_ready = 1'b0;
        start1(OP_SUB, 8'h03, 8'h05);
        wait1(8);
        for (int j = 0; j < 5; j++) begin
            bus1.in_valid = (j % 2 == 0);
            bus1.a = 8'($urandom);
            bus1.b = 8'($urandom);
            bus1.op = j[0];
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(bus1.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus1.in_ready), 32'd0);
            check("bp_result", 32'(bus1.result), 32'hFE);
            check("bp_cb", 32'(bus1.cb_out), 32'd1);
            check("bp_ovf", 32'(bus1.ovf), 32'd0);
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_rdy", 32'(bus1.in_ready), 32'd1);
        check("bp_release_vld", 32'(bus1.out_valid), 32'd0);
        check("bp_release_res", 32'(bus1.result), 32'hFE);

        start1(OP_SUB, 8'h55, 8'h22);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus1.out_valid), 32'd0);
        check("mid_rst_result", 32'(bus1.result), 32'd0);
        check("mid_rst_ready", 32'(bus1.in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start1(OP_SUB, 8'h10, 8'h01);
        wait1(8);
        check("post_rst_result", 32'(bus1.result), 32'h0F);
        check("post_rst_cb", 32'(bus1.cb_out), 32'd0);
        @(posedge clk);
        #1;

        bus4.op = OP_SUB;
        bus4.a = 8'h15;
        bus4.b = 8'h0A;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        bus4.a = 8'hFF;
        bus4.b = 8'hFF;
        bus4.op = OP_ADD;
        k = 0;
        while (!bus4.out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency4", 32'(k), 32'd2);
        check("d4_result", 32'(bus4.result), 32'h0B);
        check("d4_cb", 32'(bus4.cb_out), 32'd0);
        check("d4_ovf", 32'(bus4.ovf), 32'd0);
        @(posedge clk);
        #1;

        base = n_acc;
        bus4.op = OP_SUB;
        bus4.a = 8'h15;
        bus4.b = 8'h0A;
        bus4.in_valid = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("ii_accepts", 32'(n_acc - base), 32'd4);
        if (n_acc - base >= 3) begin
            check("ii_gap0", 32'(acc_t[base+1] - acc_t[base]), 32'd4);
            check("ii_gap1", 32'(acc_t[base+2] - acc_t[base+1]), 32'd4);
        end
        check("ii_result", 32'(bus4.result), 32'h0B);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
